// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit control, instruction-memory and instruction-stream bundle
//
// Signals (direction as seen from the fetch unit, master modport):
//   enable_i        in   fetching permitted
//   redirect_i      in   one-cycle PC replacement pulse
//   redirect_addr_i in   redirect target, bits [1:0] ignored
//   mem_req_o       out  instruction-memory read request
//   mem_addr_o      out  word-aligned read address
//   mem_ack_i       in   one-cycle read completion, data valid same cycle
//   mem_data_i      in   instruction word from memory
//   instr_valid_o   out  instr_o/instr_pc_o hold a valid instruction
//   instr_o         out  fetched instruction
//   instr_pc_o      out  address the instruction was fetched from
//   instr_ready_i   in   downstream accepts when valid && ready
interface fetch_unit_if;
    logic        enable_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    modport master (
        input  enable_i, redirect_i, redirect_addr_i, mem_ack_i, mem_data_i, instr_ready_i,
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

    modport slave (
        output enable_i, redirect_i, redirect_addr_i, mem_ack_i, mem_data_i, instr_ready_i,
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit with redirect support
//
// Ports:
//   clk_i    in  sole clock, rising edge
//   reset_i  in  asynchronous active-high reset
//   bus      fetch_unit_if.master: control, memory request/ack, instruction output
// Parameter:
//   RESET_ADDR  fetch address loaded on reset
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h00100500
) (
    input  logic          clk_i,
    input  logic          reset_i,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending;
    logic        discard;
    logic        req_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;

    logic [31:0] target;
    assign target = {bus.redirect_addr_i[31:2], 2'b00};

    // The request address is the PC register itself; a redirect arriving while
    // a request is outstanding is parked in 'pending' so the address stays put.
    assign bus.mem_addr_o    = pc;
    assign bus.mem_req_o     = req_q;
    assign bus.instr_valid_o = valid_q;
    assign bus.instr_o       = instr_q;
    assign bus.instr_pc_o    = instr_pc_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            pc         <= {RESET_ADDR[31:2], 2'b00};
            pending    <= 32'h0;
            discard    <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.redirect_i) begin
                        pc <= target;
                    end
                    if (bus.enable_i) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end

                REQ: begin
                    if (bus.mem_ack_i) begin
                        if (bus.redirect_i) begin
                            // Redirect wins over the returning word and any parked target.
                            pc      <= target;
                            discard <= 1'b0;
                            state   <= bus.enable_i ? REQ : IDLE;
                            req_q   <= bus.enable_i;
                        end else if (discard) begin
                            // Word belongs to the pre-redirect stream; now switch PC.
                            pc      <= pending;
                            discard <= 1'b0;
                            state   <= bus.enable_i ? REQ : IDLE;
                            req_q   <= bus.enable_i;
                        end else begin
                            instr_q    <= bus.mem_data_i;
                            instr_pc_q <= pc;
                            valid_q    <= 1'b1;
                            pc         <= pc + 32'd4;
                            state      <= HOLD;
                            req_q      <= 1'b0;
                        end
                    end else if (bus.redirect_i) begin
                        pending <= target;
                        discard <= 1'b1;
                    end
                end

                HOLD: begin
                    if (bus.redirect_i) begin
                        // Flush the held instruction even if it is being accepted.
                        pc      <= target;
                        valid_q <= 1'b0;
                        state   <= bus.enable_i ? REQ : IDLE;
                        req_q   <= bus.enable_i;
                    end else if (bus.instr_ready_i) begin
                        valid_q <= 1'b0;
                        state   <= bus.enable_i ? REQ : IDLE;
                        req_q   <= bus.enable_i;
                    end
                end

                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking testbench for fetch_unit
module tb_fetch_unit;

    logic clk;
    logic rst;

    fetch_unit_if bif();
    fetch_unit_if wif();

    fetch_unit #(.RESET_ADDR(32'h00100500)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bif.master)
    );

    fetch_unit #(.RESET_ADDR(32'hFFFFFFFC)) dut_wrap (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (wif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] addrs[$];
    int          vcyc[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.enable_i = 0; bif.redirect_i = 0; bif.redirect_addr_i = 0;
        bif.mem_ack_i = 0; bif.mem_data_i = 0; bif.instr_ready_i = 0;
        wif.enable_i = 0; wif.redirect_i = 0; wif.redirect_addr_i = 0;
        wif.mem_ack_i = 0; wif.mem_data_i = 0; wif.instr_ready_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        sb.delete();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
    endtask

    // Zero-wait memory, ready held high; scoreboard pushes on ack, pops on accept.
    task automatic fetch_n(input int n);
        int   got;
        int   cyc;
        exp_t e;
        got = 0;
        cyc = 0;
        addrs.delete();
        vcyc.delete();
        bif.enable_i = 1;
        bif.instr_ready_i = 1;
        while (got < n && cyc < 100) begin
            step();
            cyc++;
            if (bif.instr_valid_o && bif.instr_ready_i) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL deliver_underflow: valid with pc=%h but nothing expected", bif.instr_pc_o);
                end else begin
                    e = sb.pop_front();
                    if (bif.instr_pc_o !== e.pc || bif.instr_o !== e.instr) begin
                        n_fail++;
                        $display("FAIL deliver: got pc=%h instr=%h expected pc=%h instr=%h",
                                 bif.instr_pc_o, bif.instr_o, e.pc, e.instr);
                    end
                end
                got++;
                vcyc.push_back(cyc);
            end
            if (bif.mem_req_o && addrs.size() < n) begin
                addrs.push_back(bif.mem_addr_o);
                bif.mem_ack_i  = 1;
                bif.mem_data_i = mem_word(bif.mem_addr_o);
                e.pc = bif.mem_addr_o;
                e.instr = bif.mem_data_i;
                sb.push_back(e);
            end else begin
                bif.mem_ack_i = 0;
            end
        end
        bif.mem_ack_i = 0;
        n_checks++;
        if (got != n) begin
            n_fail++;
            $display("FAIL fetch_timeout: got %0d instructions expected %0d", got, n);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        n_checks++; if (bif.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bif.mem_req_o); end
        n_checks++; if (bif.mem_addr_o !== 32'h00100500) begin n_fail++; $display("FAIL rst_addr: got %h expected 00100500", bif.mem_addr_o); end
        n_checks++; if (bif.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bif.instr_valid_o); end
        n_checks++; if (bif.instr_o !== 32'h0 || bif.instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h/%h expected 0/0", bif.instr_o, bif.instr_pc_o); end
        n_checks++; if (wif.mem_addr_o !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL rst_wrap_addr: got %h expected fffffffc", wif.mem_addr_o); end
        rst = 0;
        bif.enable_i = 1;
        #1;
        n_checks++; if (bif.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL release_req: got %b expected 0", bif.mem_req_o); end
        step();
        n_checks++; if (bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00100500) begin n_fail++; $display("FAIL first_req: got req=%b addr=%h expected 1/00100500", bif.mem_req_o, bif.mem_addr_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        do_reset();
        fetch_n(3);
        exp_addr = 32'h00100500;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= addrs.size() || addrs[i] !== exp_addr) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got %h expected %h", i, (i < addrs.size()) ? addrs[i] : 32'hx, exp_addr);
            end
            exp_addr = exp_addr + 4;
        end
        for (int i = 1; i < vcyc.size(); i++) begin
            n_checks++;
            if (vcyc[i] - vcyc[i-1] != 2) begin
                n_fail++;
                $display("FAIL throughput%0d: got spacing %0d expected 2", i, vcyc[i] - vcyc[i-1]);
            end
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL seq_leftover: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_wait_state();
        exp_t e;
        do_reset();
        bif.enable_i = 1;
        step();
        bif.enable_i = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00100500) begin
                n_fail++;
                $display("FAIL wait_stable%0d: got req=%b addr=%h expected 1/00100500", i, bif.mem_req_o, bif.mem_addr_o);
            end
        end
        bif.mem_ack_i = 1;
        bif.mem_data_i = mem_word(32'h00100500);
        e.pc = 32'h00100500;
        e.instr = bif.mem_data_i;
        sb.push_back(e);
        step();
        bif.mem_ack_i = 0;
        bif.instr_ready_i = 1;
        e = sb.pop_front();
        n_checks++;
        if (bif.instr_valid_o !== 1'b1 || bif.instr_pc_o !== e.pc || bif.instr_o !== e.instr) begin
            n_fail++;
            $display("FAIL wait_deliver: got v=%b pc=%h instr=%h expected 1/%h/%h", bif.instr_valid_o, bif.instr_pc_o, bif.instr_o, e.pc, e.instr);
        end
        step();
        n_checks++; if (bif.mem_req_o !== 1'b0 || bif.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL wait_idle: got req=%b v=%b expected 0/0", bif.mem_req_o, bif.instr_valid_o); end
        step();
        n_checks++; if (bif.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL wait_idle2: got req=%b expected 0", bif.mem_req_o); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset();
        bif.enable_i = 1;
        step();
        bif.mem_ack_i = 1;
        bif.mem_data_i = mem_word(32'h00100500);
        e.pc = 32'h00100500;
        e.instr = bif.mem_data_i;
        sb.push_back(e);
        step();
        bif.mem_ack_i = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bif.instr_valid_o !== 1'b1 || bif.instr_o !== sb[0].instr || bif.instr_pc_o !== sb[0].pc || bif.mem_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL hold%0d: got v=%b instr=%h pc=%h req=%b expected 1/%h/%h/0",
                         i, bif.instr_valid_o, bif.instr_o, bif.instr_pc_o, bif.mem_req_o, sb[0].instr, sb[0].pc);
            end
        end
        bif.instr_ready_i = 1;
        e = sb.pop_front();
        n_checks++; if (bif.instr_o !== e.instr || bif.instr_pc_o !== e.pc) begin n_fail++; $display("FAIL hold_accept: got %h/%h expected %h/%h", bif.instr_o, bif.instr_pc_o, e.instr, e.pc); end
        step();
        bif.instr_ready_i = 0;
        n_checks++; if (bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00100504) begin n_fail++; $display("FAIL hold_next: got req=%b addr=%h expected 1/00100504", bif.mem_req_o, bif.mem_addr_o); end
    endtask

    task automatic test_redirect_req();
        exp_t e;
        do_reset();
        fetch_n(2);
        step();
        n_checks++; if (bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00100508) begin n_fail++; $display("FAIL rdq_pre: got req=%b addr=%h expected 1/00100508", bif.mem_req_o, bif.mem_addr_o); end
        bif.redirect_i = 1;
        bif.redirect_addr_i = 32'h00000203;
        step();
        bif.redirect_i = 0;
        n_checks++; if (bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00100508) begin n_fail++; $display("FAIL rdq_stable: got req=%b addr=%h expected 1/00100508", bif.mem_req_o, bif.mem_addr_o); end
        bif.mem_ack_i = 1;
        bif.mem_data_i = mem_word(32'h00100508);
        step();
        bif.mem_ack_i = 0;
        n_checks++; if (bif.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rdq_discard: got valid=%b expected 0", bif.instr_valid_o); end
        n_checks++; if (bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00000200) begin n_fail++; $display("FAIL rdq_target: got req=%b addr=%h expected 1/00000200", bif.mem_req_o, bif.mem_addr_o); end
        bif.mem_ack_i = 1;
        bif.mem_data_i = mem_word(32'h00000200);
        e.pc = 32'h00000200;
        e.instr = bif.mem_data_i;
        sb.push_back(e);
        step();
        bif.mem_ack_i = 0;
        e = sb.pop_front();
        n_checks++; if (bif.instr_valid_o !== 1'b1 || bif.instr_pc_o !== e.pc || bif.instr_o !== e.instr) begin n_fail++; $display("FAIL rdq_deliver: got v=%b pc=%h instr=%h expected 1/%h/%h", bif.instr_valid_o, bif.instr_pc_o, bif.instr_o, e.pc, e.instr); end
    endtask

    task automatic test_redirect_hold();
        exp_t e;
        do_reset();
        bif.enable_i = 1;
        step();
        bif.mem_ack_i = 1;
        bif.mem_data_i = mem_word(32'h00100500);
        step();
        bif.mem_ack_i = 0;
        n_checks++; if (bif.instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL rdh_pre: got valid=%b expected 1", bif.instr_valid_o); end
        bif.instr_ready_i = 1;
        bif.redirect_i = 1;
        bif.redirect_addr_i = 32'h00001237;
        step();
        bif.redirect_i = 0;
        n_checks++; if (bif.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rdh_flush: got valid=%b expected 0", bif.instr_valid_o); end
        n_checks++; if (bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00001234) begin n_fail++; $display("FAIL rdh_target: got req=%b addr=%h expected 1/00001234", bif.mem_req_o, bif.mem_addr_o); end
        // Redirect coincident with ack: word dropped, no discard left behind.
        bif.mem_ack_i = 1;
        bif.mem_data_i = mem_word(32'h00001234);
        bif.redirect_i = 1;
        bif.redirect_addr_i = 32'h00003000;
        step();
        bif.mem_ack_i = 0;
        bif.redirect_i = 0;
        n_checks++; if (bif.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rda_drop: got valid=%b expected 0", bif.instr_valid_o); end
        n_checks++; if (bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00003000) begin n_fail++; $display("FAIL rda_target: got req=%b addr=%h expected 1/00003000", bif.mem_req_o, bif.mem_addr_o); end
        bif.mem_ack_i = 1;
        bif.mem_data_i = mem_word(32'h00003000);
        e.pc = 32'h00003000;
        e.instr = bif.mem_data_i;
        sb.push_back(e);
        step();
        bif.mem_ack_i = 0;
        e = sb.pop_front();
        n_checks++; if (bif.instr_valid_o !== 1'b1 || bif.instr_pc_o !== e.pc || bif.instr_o !== e.instr) begin n_fail++; $display("FAIL rda_deliver: got v=%b pc=%h instr=%h expected 1/%h/%h", bif.instr_valid_o, bif.instr_pc_o, bif.instr_o, e.pc, e.instr); end
    endtask

    task automatic test_wrap();
        do_reset();
        wif.enable_i = 1;
        wif.instr_ready_i = 1;
        step();
        n_checks++; if (wif.mem_req_o !== 1'b1 || wif.mem_addr_o !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_first: got req=%b addr=%h expected 1/fffffffc", wif.mem_req_o, wif.mem_addr_o); end
        wif.mem_ack_i = 1;
        wif.mem_data_i = mem_word(32'hFFFFFFFC);
        step();
        wif.mem_ack_i = 0;
        n_checks++; if (wif.instr_valid_o !== 1'b1 || wif.instr_pc_o !== 32'hFFFFFFFC || wif.instr_o !== mem_word(32'hFFFFFFFC)) begin n_fail++; $display("FAIL wrap_deliver: got v=%b pc=%h instr=%h expected 1/fffffffc/%h", wif.instr_valid_o, wif.instr_pc_o, wif.instr_o, mem_word(32'hFFFFFFFC)); end
        step();
        n_checks++; if (wif.mem_req_o !== 1'b1 || wif.mem_addr_o !== 32'h00000000) begin n_fail++; $display("FAIL wrap_second: got req=%b addr=%h expected 1/00000000", wif.mem_req_o, wif.mem_addr_o); end
        wif.enable_i = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bif.enable_i = 1;
        bif.instr_ready_i = 1;
        step();
        bif.mem_ack_i = 1;
        bif.mem_data_i = mem_word(32'h00100500);
        step();
        bif.mem_ack_i = 0;
        step();
        n_checks++; if (bif.mem_req_o !== 1'b1 || bif.instr_pc_o !== 32'h00100500) begin n_fail++; $display("FAIL ar_pre: got req=%b pc=%h expected 1/00100500", bif.mem_req_o, bif.instr_pc_o); end
        rst = 1;
        #1;
        n_checks++;
        if (bif.mem_req_o !== 1'b0 || bif.instr_valid_o !== 1'b0 || bif.instr_o !== 32'h0 ||
            bif.instr_pc_o !== 32'h0 || bif.mem_addr_o !== 32'h00100500) begin
            n_fail++;
            $display("FAIL ar_async: got req=%b v=%b instr=%h pc=%h addr=%h expected 0/0/0/0/00100500",
                     bif.mem_req_o, bif.instr_valid_o, bif.instr_o, bif.instr_pc_o, bif.mem_addr_o);
        end
        step();
        rst = 0;
        bif.mem_ack_i = 1;
        bif.mem_data_i = 32'hDEADBEEF;
        step();
        bif.mem_ack_i = 0;
        n_checks++; if (bif.instr_valid_o !== 1'b0 || bif.mem_req_o !== 1'b1 || bif.mem_addr_o !== 32'h00100500) begin n_fail++; $display("FAIL ar_stale_ack: got v=%b req=%b addr=%h expected 0/1/00100500", bif.instr_valid_o, bif.mem_req_o, bif.mem_addr_o); end
        step();
        n_checks++; if (bif.instr_valid_o !== 1'b0 || bif.mem_addr_o !== 32'h00100500) begin n_fail++; $display("FAIL ar_restart: got v=%b addr=%h expected 0/00100500", bif.instr_valid_o, bif.mem_addr_o); end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_wait_state();
        test_backpressure();
        test_redirect_req();
        test_redirect_hold();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
